rx_frame_fifo: RTL

Receive-side frame buffer sitting directly downstream of the UART receiver. Captures each completed frame (8 data bits plus received parity bit) on a one-cycle valid strobe and checks parity against the configured mode. Stores the data byte and its parity-error flag in a DEPTH-entry FIFO, and presents them to the host side with a pop handshake, status flags, a sticky overrun flag and a level interrupt.

---
 rtl/rx_frame_fifo.sv | 113 +++++++++++
 1 files changed

// File: rtl/rx_frame_fifo.sv
// Receive frame buffer behind the UART receiver: parity check, FWFT FIFO,
// sticky overrun, saturating parity-error counter and level interrupt.
module rx_frame_fifo #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int IRQ_LEVEL = 1
) (
  input  logic          uart_clk,
  input  logic          RST,
  input  logic          frame_valid,
  input  logic [7:0]    frame_data,
  input  logic          frame_par,
  input  logic [1:0]    parity_mode,
  input  logic          rd_en,
  input  logic          clr,
  output logic [7:0]    rd_data,
  output logic          rd_perr,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic [7:0]    perr_cnt,
  output logic          irq
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] IRQ_CNT  = (AW+1)'(IRQ_LEVEL);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          frame_x;
  logic          perr;
  logic          push;
  logic          pop;
  logic          drop;

  always_comb begin
    frame_x = ^frame_data ^ frame_par;
    perr    = 1'b0;
    case (parity_mode)
      2'b01:   perr = frame_x;
      2'b10:   perr = ~frame_x;
      default: perr = 1'b0;
    endcase
  end

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);
  assign irq   = (cnt >= IRQ_CNT);
  assign count = cnt;

  // A pop frees a slot in the same cycle, so full does not block a push then.
  assign pop  = rd_en & ~empty;
  assign push = frame_valid & (~full | pop);
  assign drop = frame_valid & full & ~rd_en;

  assign rd_data = mem[rd_ptr][7:0];
  assign rd_perr = mem[rd_ptr][8];

  always_ff @(posedge uart_clk or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !clr) begin
      mem[wr_ptr] <= {perr, frame_data};
    end
  end

  always_ff @(posedge uart_clk or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge uart_clk or negedge RST) begin
    if (!RST) begin
      overrun  <= 1'b0;
      perr_cnt <= '0;
    end else if (clr) begin
      overrun  <= 1'b0;
      perr_cnt <= '0;
    end else begin
      if (drop) begin
        overrun <= 1'b1;
      end
      if (push && perr && perr_cnt != 8'hFF) begin
        perr_cnt <= perr_cnt + 8'd1;
      end
    end
  end

endmodule
